// File: rtl/juiz_mao.sv
// Truco hand referee: records trick results, decides the hand winner and pulses
// IA/IB once per point at stake. Optional stake raise enabled by macro TRUCO_EN.
module juiz_mao (
    input  logic       Clk,
    input  logic       Clr_n,
    input  logic       trick_valid,
    input  logic [1:0] trick_res,
    input  logic       truco,
    output logic       IA,
    output logic       IB,
    output logic       hand_done,
    output logic       busy,
    output logic [1:0] stake,
    output logic [1:0] trick_cnt
);

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_A    = 2'b01;
    localparam logic [1:0] RES_B    = 2'b10;
    localparam logic [1:0] RES_TIE  = 2'b11;
    localparam logic [1:0] STAKE_LO = 2'd1;
    localparam logic [1:0] STAKE_HI = 2'd3;

    typedef enum logic [1:0] {PLAY, AWARD, DONE} state_e;

    state_e     state_q, state_d;
    logic [1:0] t1_q, t1_d, t2_q, t2_d, t3_q, t3_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] stake_q, stake_d;
    logic [1:0] award_q, award_d;
    logic       win_b_q, win_b_d;
    logic       ia_q, ia_d, ib_q, ib_d, done_q, done_d, busy_q, busy_d;
    logic       truco_acc_c;
    logic [1:0] stake_eff_c;
    logic [2:0] verdict_c;

    // Returns {resolved, has_winner, winner_is_b}; unrecorded tricks read as RES_NONE.
    function automatic logic [2:0] decide(input logic [1:0] t1, input logic [1:0] t2,
                                          input logic [1:0] t3);
        logic [1:0] a_w;
        logic [1:0] b_w;
        logic [2:0] r;
        a_w = 2'(t1 == RES_A) + 2'(t2 == RES_A) + 2'(t3 == RES_A);
        b_w = 2'(t1 == RES_B) + 2'(t2 == RES_B) + 2'(t3 == RES_B);
        r   = 3'b000;
        if (a_w >= 2'd2)                                        r = 3'b110;
        else if (b_w >= 2'd2)                                   r = 3'b111;
        else if (t1 == RES_TIE && (t2 == RES_A || t2 == RES_B)) r = {2'b11, t2 == RES_B};
        else if ((t1 == RES_A || t1 == RES_B) && t2 == RES_TIE) r = {2'b11, t1 == RES_B};
        else if ((t1 == RES_A || t1 == RES_B) && (t2 == RES_A || t2 == RES_B) && t3 == RES_TIE)
                                                                r = {2'b11, t1 == RES_B};
        else if (t1 == RES_TIE && t2 == RES_TIE && (t3 == RES_A || t3 == RES_B))
                                                                r = {2'b11, t3 == RES_B};
        else if (t1 == RES_TIE && t2 == RES_TIE && t3 == RES_TIE) r = 3'b100;
        return r;
    endfunction

`ifdef TRUCO_EN
    assign truco_acc_c = truco && (state_q == PLAY) && (stake_q == STAKE_LO);
`else
    logic unused_truco;
    assign unused_truco = truco;
    assign truco_acc_c  = 1'b0;
`endif

    assign stake_eff_c = truco_acc_c ? STAKE_HI : stake_q;

    always_comb begin
        state_d   = state_q;
        t1_d      = t1_q;
        t2_d      = t2_q;
        t3_d      = t3_q;
        cnt_d     = cnt_q;
        stake_d   = stake_q;
        award_d   = award_q;
        win_b_d   = win_b_q;
        verdict_c = 3'b000;
        case (state_q)
            PLAY: begin
                stake_d = stake_eff_c;
                if (trick_valid && trick_res != RES_NONE) begin
                    cnt_d = cnt_q + 2'd1;
                    case (cnt_q)
                        2'd0:    t1_d = trick_res;
                        2'd1:    t2_d = trick_res;
                        default: t3_d = trick_res;
                    endcase
                    verdict_c = decide(t1_d, t2_d, t3_d);
                    if (verdict_c[2] && verdict_c[1]) begin
                        state_d = AWARD;
                        award_d = stake_eff_c;
                        win_b_d = verdict_c[0];
                    end else if (verdict_c[2]) begin
                        state_d = DONE;
                    end
                end
            end
            AWARD: begin
                // award_q counts the remaining pulse cycles including this one
                if (award_q <= 2'd1) state_d = DONE;
                else                 award_d = award_q - 2'd1;
            end
            DONE: begin
                state_d = PLAY;
                cnt_d   = 2'd0;
                t1_d    = RES_NONE;
                t2_d    = RES_NONE;
                t3_d    = RES_NONE;
                stake_d = STAKE_LO;
            end
            default: state_d = PLAY;
        endcase
        ia_d   = (state_d == AWARD) && !win_b_d;
        ib_d   = (state_d == AWARD) &&  win_b_d;
        done_d = (state_d == DONE);
        busy_d = (state_d != PLAY);
    end

    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            state_q <= PLAY;
            t1_q    <= RES_NONE;
            t2_q    <= RES_NONE;
            t3_q    <= RES_NONE;
            cnt_q   <= 2'd0;
            stake_q <= STAKE_LO;
            award_q <= 2'd0;
            win_b_q <= 1'b0;
            ia_q    <= 1'b0;
            ib_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t1_q    <= t1_d;
            t2_q    <= t2_d;
            t3_q    <= t3_d;
            cnt_q   <= cnt_d;
            stake_q <= stake_d;
            award_q <= award_d;
            win_b_q <= win_b_d;
            ia_q    <= ia_d;
            ib_q    <= ib_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign IA        = ia_q;
    assign IB        = ib_q;
    assign hand_done = done_q;
    assign busy      = busy_q;
    assign stake     = stake_q;
    assign trick_cnt = cnt_q;

endmodule

// File: tb/tb_juiz_mao.sv
// Scoreboard bench for juiz_mao: expected per-hand points are queued by the driver
// and checked by a monitor on every hand_done.
module tb_juiz_mao;

`ifdef TRUCO_EN
    localparam int STK = 3;
`else
    localparam int STK = 1;
`endif

    logic       Clk = 1'b0;
    logic       Clr_n;
    logic       trick_valid;
    logic [1:0] trick_res;
    logic       truco;
    logic       IA, IB, hand_done, busy;
    logic [1:0] stake, trick_cnt;

    juiz_mao dut (
        .Clk(Clk), .Clr_n(Clr_n), .trick_valid(trick_valid), .trick_res(trick_res),
        .truco(truco), .IA(IA), .IB(IB), .hand_done(hand_done), .busy(busy),
        .stake(stake), .trick_cnt(trick_cnt)
    );

    always #5 Clk = ~Clk;

    typedef struct { int a; int b; } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Monitor: tally IA/IB cycles per hand and compare against the queue on hand_done.
    int   acc_a = 0, acc_b = 0;
    logic both_seen = 1'b0, prev_pulse = 1'b0;
    always @(negedge Clk) begin
        exp_t e;
        if (!Clr_n) begin
            acc_a = 0; acc_b = 0; both_seen = 1'b0; prev_pulse = 1'b0;
        end else if (hand_done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_hand_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("points_a", acc_a, e.a);
                check("points_b", acc_b, e.b);
                check("award_ends_before_done", int'(prev_pulse), int'(e.a + e.b > 0));
                check("ia_ib_exclusive", int'(both_seen), 0);
                check("busy_in_done", int'(busy), 1);
            end
            acc_a = 0; acc_b = 0; both_seen = 1'b0; prev_pulse = 1'b0;
        end else begin
            if (IA) acc_a++;
            if (IB) acc_b++;
            if (IA && IB) both_seen = 1'b1;
            prev_pulse = IA | IB;
        end
    end

    task automatic push_exp(input int a, input int b);
        exp_t e;
        e.a = a; e.b = b;
        exp_q.push_back(e);
    endtask

    // Holds the inputs for exactly one sampling edge, returns 1 time unit after it.
    task automatic drive(input logic v, input logic [1:0] code, input logic tr);
        trick_valid = v; trick_res = code; truco = tr;
        @(posedge Clk); #1;
        trick_valid = 1'b0; trick_res = 2'b00; truco = 1'b0;
    endtask

    task automatic idle();
        @(posedge Clk); #1;
    endtask

    task automatic finish_hand(input string name);
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            idle();
        end
        check({name, "_closes"}, int'(busy), 0);
        check({name, "_stake_reset"}, int'(stake), 1);
        check({name, "_cnt_reset"}, int'(trick_cnt), 0);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_IA"}, int'(IA), 0);
        check({name, "_IB"}, int'(IB), 0);
        check({name, "_hand_done"}, int'(hand_done), 0);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_stake"}, int'(stake), 1);
        check({name, "_trick_cnt"}, int'(trick_cnt), 0);
    endtask

    initial begin
        Clr_n = 1'b0; trick_valid = 1'b0; trick_res = 2'b00; truco = 1'b0;
        #12;
        check_reset_vals("in_reset");
        Clr_n = 1'b1;
        idle();
        check_reset_vals("after_reset");

        // A, A -> team A wins one point
        push_exp(1, 0);
        drive(1'b1, 2'b01, 1'b0);
        check("h1_cnt_after_first", int'(trick_cnt), 1);
        check("h1_not_busy", int'(busy), 0);
        drive(1'b1, 2'b01, 1'b0);
        check("h1_busy_award", int'(busy), 1);
        check("h1_IA_award", int'(IA), 1);
        finish_hand("h1");

        // truco (repeated), then A, B, A
        drive(1'b0, 2'b00, 1'b1);
        check("h2_stake_raised", int'(stake), STK);
        drive(1'b0, 2'b00, 1'b1);
        check("h2_stake_repeat", int'(stake), STK);
        push_exp(STK, 0);
        drive(1'b1, 2'b01, 1'b0);
        drive(1'b1, 2'b10, 1'b0);
        check("h2_cnt_two", int'(trick_cnt), 2);
        drive(1'b1, 2'b01, 1'b0);
        finish_hand("h2");

        // tie, B -> B
        push_exp(0, 1);
        drive(1'b1, 2'b11, 1'b0);
        drive(1'b1, 2'b10, 1'b0);
        finish_hand("h3");

        // A, B, tie -> first-trick winner A
        push_exp(1, 0);
        drive(1'b1, 2'b01, 1'b0);
        drive(1'b1, 2'b10, 1'b0);
        drive(1'b1, 2'b11, 1'b0);
        finish_hand("h4");

        // three ties -> no winner
        push_exp(0, 0);
        drive(1'b1, 2'b11, 1'b0);
        drive(1'b1, 2'b11, 1'b0);
        check("h5_cnt_two", int'(trick_cnt), 2);
        drive(1'b1, 2'b11, 1'b0);
        check("h5_busy_done", int'(busy), 1);
        finish_hand("h5");

        // illegal code and a trick during AWARD are both ignored
        push_exp(0, 1);
        drive(1'b1, 2'b10, 1'b0);
        drive(1'b1, 2'b00, 1'b0);
        check("h6_illegal_ignored", int'(trick_cnt), 1);
        drive(1'b1, 2'b10, 1'b0);
        drive(1'b1, 2'b01, 1'b0);
        check("h6_award_trick_ignored", int'(trick_cnt), 2);
        finish_hand("h6");

        // truco in the same cycle as the deciding trick
        push_exp(0, STK);
        drive(1'b1, 2'b10, 1'b0);
        drive(1'b1, 2'b10, 1'b1);
        check("h7_stake_same_cycle", int'(stake), STK);
        finish_hand("h7");

        // reset in the second award cycle: no completion, no hand_done
        drive(1'b0, 2'b00, 1'b1);
        drive(1'b1, 2'b01, 1'b0);
        drive(1'b1, 2'b01, 1'b0);
        idle();
        check("h8_IA_second_cycle", int'(IA), int'(STK == 3));
        #1 Clr_n = 1'b0;
        #1 check_reset_vals("mid_award_reset");
        idle();
        idle();
        Clr_n = 1'b1;
        idle();
        check_reset_vals("after_mid_reset");
        for (int i = 0; i < 4; i++) idle();

        // fresh hand after reset: tie, B -> B
        push_exp(0, 1);
        drive(1'b1, 2'b11, 1'b0);
        check("h9_cnt_one", int'(trick_cnt), 1);
        drive(1'b1, 2'b10, 1'b0);
        finish_hand("h9");

        for (int i = 0; i < 3; i++) idle();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
